prbs_checker: RTL
=================

# prbs_checker

Receive-side PRBS-15 checker for the byte-wide PRBS stream produced by the PRBS generator in the top-level module. It self-synchronises to the incoming bytes and declares lock after a run of error-free bytes. While locked, it compares each byte against a local free-running LFSR and counts bit errors. It loses lock after consecutive errored bytes. It sits on the link-test receive path, downstream of the pattern detector.

## Interface
- LOCK_CNT, 4: consecutive error-free bytes in VERIFY needed to assert lock (1..15).
- LOSS_CNT, 3: consecutive errored bytes in LOCKED that drop lock (1..15).
- CNT_W, 16: width of the error counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  received PRBS byte; bit 7 is the oldest bit in time.
- data_valid  in  1  data_in is valid this cycle; invalid cycles hold all state.
- locked  out  1  checker is in LOCKED state.
- byte_err  out  1  one-cycle pulse: the last valid byte checked in LOCKED had at least one mismatching bit.
- bit_err_num  out  4  number of mismatching bits in the last checked byte (0..8); valid with byte_err.
- err_cnt  out  CNT_W  accumulated bit errors while locked; saturates at all-ones.
- clr_cnt  in  1  synchronous clear of err_cnt; has priority over increment.

## Operation
- Polynomial x^15 + x^14 + 1. Serial step: nb = s[14] ^ s[13]; s <= {s[13:0], nb}. Eight steps per byte; the first generated bit is data_in[7].
- The state register hist[14:0] always holds the last 15 received bits, newest at bit 0. It updates on every valid byte in all states.
- SEED: collects 2 valid bytes into hist, then goes to VERIFY. No error outputs.
- VERIFY (self-synchronous check): each received bit is predicted as hist-tap XOR, computed sequentially across the byte.
  - Error-free byte: good_run++. Errored byte: good_run = 0.
  - When good_run reaches LOCK_CNT, go to LOCKED and load lfsr with the post-update hist.
  - No error outputs in this state.
- LOCKED: the expected byte is the next 8 bits of lfsr, and lfsr advances 8 steps on each valid byte.
  - mismatch = data_in ^ expected. bit_err_num = popcount(mismatch). byte_err = |mismatch.
  - err_cnt += popcount, saturating.
  - bad_run++ on an errored byte; bad_run = 0 on a clean byte. bad_run == LOSS_CNT → SEED, with locked dropping on the same edge.
- A single injected bit error counts exactly 1 in LOCKED, because the LFSR is not fed from received data.
- Simultaneous clr_cnt and an errored byte: err_cnt = 0, and that byte's errors are dropped.
- If rst asserts mid-byte or mid-run, all state returns to reset immediately.

## Timing
- Reset values: locked 0, byte_err 0, bit_err_num 0, err_cnt 0. FSM in SEED; hist, lfsr, good_run and bad_run are 0.
- All outputs are registered. byte_err and bit_err_num appear one clock after the valid byte is sampled. err_cnt updates on the same edge.
- Lock latency from the first valid byte of a clean stream: 2 + LOCK_CNT valid bytes. locked rises on the edge that samples the last of these bytes.
- Loss latency: LOSS_CNT consecutive errored valid bytes.
- data_valid low: no state change, and byte_err is 0.

## Configuration
- PRBS_CHECKER_ERRCNT_EN defined: err_cnt accumulator and clr_cnt are implemented as described.
- Not defined: err_cnt is tied to 0 and clr_cnt is ignored. locked, byte_err and bit_err_num are unchanged.

## Structure
- Shared package prbs_pkg holds:
  - PRBS15 tap constants (14, 13) and the state-width constant 15.
  - FSM state enum: SEED, VERIFY, LOCKED.
  - Byte-step function: 15-bit state in, returns next state and 8-bit output.
- One natural sub-module, prbs_popcount8: combinational 8-bit population count giving a 4-bit result.

## Test plan
- Clean stream from the reference LFSR seeded 15'h7FFF, one valid byte per clock, defaults → locked = 1 after the 6th valid byte; err_cnt stays 0 over 100 bytes.
- Once locked, flip data_in[0] of one byte → byte_err pulses for one cycle, bit_err_num = 1, err_cnt = 1. The next byte is clean and locked holds.
- Once locked, invert 3 consecutive bytes (0xFF mask) → err_cnt = 24 and locked drops on the 3rd byte. The clean stream then relocks after 6 further valid bytes.
- Gap data_valid low for 5 cycles in the middle of VERIFY → good_run is preserved and lock is reached after the same total of 6 valid bytes.
- Preload err_cnt to 0xFFFE (CNT_W = 16), then apply an errored byte with 3 bit errors → err_cnt = 0xFFFF. Asserting clr_cnt together with an errored byte → err_cnt = 0.
- Assert rst while locked with err_cnt = 5 → locked = 0 and err_cnt = 0 immediately, without waiting for a clock edge. After release, relock takes 6 valid bytes.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions: polynomial taps, checker FSM states and the
// byte-wide LFSR step used by both the free-running and self-sync checks.
package prbs_pkg;

    localparam int PRBS_W = 15;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 13;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [PRBS_W-1:0] state;
        logic [7:0]        data;
    } step_t;

    // Eight serial steps; the first generated bit lands in data[7].
    function automatic step_t prbs_byte_step(input logic [PRBS_W-1:0] s);
        step_t             r;
        logic [PRBS_W-1:0] t;
        logic              nb;
        t = s;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            nb        = t[TAP_A] ^ t[TAP_B];
            t         = {t[PRBS_W-2:0], nb};
            r.data[i] = nb;
        end
        r.state = t;
        return r;
    endfunction

    // Self-synchronous check: each bit is predicted from the received history,
    // which includes earlier bits of the same byte.
    function automatic logic prbs_self_check_err(input logic [PRBS_W-1:0] hist,
                                                 input logic [7:0]        data);
        logic [PRBS_W-1:0] h;
        logic              err;
        h   = hist;
        err = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            err = err | ((h[TAP_A] ^ h[TAP_B]) ^ data[i]);
            h   = {h[PRBS_W-2:0], data[i]};
        end
        return err;
    endfunction

endpackage

// File: rtl/prbs_popcount8.sv
// Combinational population count of an 8-bit vector (result 0..8).
module prbs_popcount8 (
    input  logic [7:0] bits,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'd0, bits[i]};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Byte-wide PRBS-15 receive checker: self-synchronises, locks, then counts bit
// errors against a free-running LFSR. Define PRBS_CHECKER_ERRCNT_EN for err_cnt.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             locked,
    output logic             byte_err,
    output logic [3:0]       bit_err_num,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    state_t            state_q, state_d;
    logic [PRBS_W-1:0] hist_q, hist_d;
    logic [PRBS_W-1:0] lfsr_q, lfsr_d;
    logic [3:0]        good_run_q, good_run_d;
    logic [3:0]        bad_run_q, bad_run_d;
    logic              seed_cnt_q, seed_cnt_d;
    logic              locked_q, locked_d;
    logic              byte_err_q, byte_err_d;
    logic [3:0]        bit_err_num_q, bit_err_num_d;

    step_t             step;
    logic [7:0]        mismatch;
    logic [3:0]        pop;
    logic              verify_err;
    logic [PRBS_W-1:0] hist_upd;
    logic              lock_hit;
    logic              loss_hit;
    logic              in_locked;

    assign step       = prbs_byte_step(lfsr_q);
    assign mismatch   = data_in ^ step.data;
    assign verify_err = prbs_self_check_err(hist_q, data_in);
    assign hist_upd   = {hist_q[PRBS_W-9:0], data_in};
    assign in_locked  = data_valid && (state_q == LOCKED);
    assign lock_hit   = data_valid && (state_q == VERIFY) && !verify_err
                        && ((good_run_q + 4'd1) == LOCK_TGT);
    assign loss_hit   = in_locked && (|mismatch) && ((bad_run_q + 4'd1) == LOSS_TGT);

    prbs_popcount8 u_popcount (
        .bits  (mismatch),
        .count (pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (data_valid) begin
            case (state_q)
                SEED:    if (seed_cnt_q) state_d = VERIFY;
                VERIFY:  if (lock_hit)   state_d = LOCKED;
                LOCKED:  if (loss_hit)   state_d = SEED;
                default: state_d = SEED;
            endcase
        end
    end

    always_comb begin
        hist_d     = hist_q;
        lfsr_d     = lfsr_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        seed_cnt_d = seed_cnt_q;
        if (data_valid) begin
            hist_d = hist_upd;
            case (state_q)
                SEED: begin
                    seed_cnt_d = ~seed_cnt_q;
                    good_run_d = 4'd0;
                    bad_run_d  = 4'd0;
                end
                VERIFY: begin
                    good_run_d = verify_err ? 4'd0 : good_run_q + 4'd1;
                    if (lock_hit) begin
                        lfsr_d     = hist_upd;
                        good_run_d = 4'd0;
                        bad_run_d  = 4'd0;
                    end
                end
                LOCKED: begin
                    lfsr_d    = step.state;
                    bad_run_d = (|mismatch) ? bad_run_q + 4'd1 : 4'd0;
                    if (loss_hit) begin
                        bad_run_d  = 4'd0;
                        good_run_d = 4'd0;
                        seed_cnt_d = 1'b0;
                    end
                end
                default: begin
                    seed_cnt_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs are registered, so they are computed from the next state.
    always_comb begin
        locked_d      = (state_d == LOCKED);
        byte_err_d    = in_locked && (|mismatch);
        bit_err_num_d = in_locked ? pop : bit_err_num_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q        <= '0;
            lfsr_q        <= '0;
            good_run_q    <= 4'd0;
            bad_run_q     <= 4'd0;
            seed_cnt_q    <= 1'b0;
            locked_q      <= 1'b0;
            byte_err_q    <= 1'b0;
            bit_err_num_q <= 4'd0;
        end else begin
            hist_q        <= hist_d;
            lfsr_q        <= lfsr_d;
            good_run_q    <= good_run_d;
            bad_run_q     <= bad_run_d;
            seed_cnt_q    <= seed_cnt_d;
            locked_q      <= locked_d;
            byte_err_q    <= byte_err_d;
            bit_err_num_q <= bit_err_num_d;
        end
    end

    assign locked      = locked_q;
    assign byte_err    = byte_err_q;
    assign bit_err_num = bit_err_num_q;

`ifdef PRBS_CHECKER_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W:0]   err_sum;

    assign err_sum = {1'b0, err_cnt_q} + {{(CNT_W-3){1'b0}}, pop};

    // Clear wins over accumulation; the sum saturates at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (in_locked) begin
            err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic clr_cnt_unused;
    assign clr_cnt_unused = clr_cnt;
    assign err_cnt        = '0;
`endif

endmodule
